// File: rtl/mult_div_pkg.sv
// mult_div_pkg: op codes, FSM encoding and op-class predicates for the multiply/divide unit
package mult_div_pkg;
  localparam int MD_OP_WIDTH = 4;
  localparam logic [MD_OP_WIDTH-1:0] OP_NOP   = 4'd0;
  localparam logic [MD_OP_WIDTH-1:0] OP_MULT  = 4'd1;
  localparam logic [MD_OP_WIDTH-1:0] OP_MULTU = 4'd2;
  localparam logic [MD_OP_WIDTH-1:0] OP_DIV   = 4'd3;
  localparam logic [MD_OP_WIDTH-1:0] OP_DIVU  = 4'd4;
  localparam logic [MD_OP_WIDTH-1:0] OP_MADD  = 4'd5;
  localparam logic [MD_OP_WIDTH-1:0] OP_MADDU = 4'd6;
  localparam logic [MD_OP_WIDTH-1:0] OP_MSUB  = 4'd7;
  localparam logic [MD_OP_WIDTH-1:0] OP_MSUBU = 4'd8;
  localparam logic [MD_OP_WIDTH-1:0] OP_MTHI  = 4'd9;
  localparam logic [MD_OP_WIDTH-1:0] OP_MTLO  = 4'd10;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  function automatic logic is_mult_class(input logic [MD_OP_WIDTH-1:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction
  function automatic logic is_div_class(input logic [MD_OP_WIDTH-1:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction
  function automatic logic is_mt(input logic [MD_OP_WIDTH-1:0] op);
    return op inside {OP_MTHI, OP_MTLO};
  endfunction
  function automatic logic is_signed_op(input logic [MD_OP_WIDTH-1:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction
endpackage

// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between EX-stage control and the multiply/divide unit
interface mult_div_if import mult_div_pkg::*; #(parameter int WIDTH = 32);
  logic                   start;
  logic [MD_OP_WIDTH-1:0] op;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   cancel;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       hi;
  logic [WIDTH-1:0]       lo;
  modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_arith.sv
// mult_div_arith: combinational {HI,LO} result for multiply, accumulate and divide ops
module mult_div_arith import mult_div_pkg::*; #(parameter int WIDTH = 32) (
  input  logic [MD_OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic [2*WIDTH-1:0]     hilo,
  output logic [2*WIDTH-1:0]     res
);
  logic             sgn, a_neg, b_neg, b_zero;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, div_res;
  logic [WIDTH-1:0] ua, ub, uq, ur, q, r;
  always_comb begin
    sgn = is_signed_op(op);
    a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod = a_ext * b_ext;
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    b_zero = b == '0;
    // magnitude divide; MIN/-1 falls out as MIN, 0 through the mod-2^WIDTH negate
    ua = a_neg ? -a : a;
    ub = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : (b_neg ? -b : b);
    uq = ua / ub;
    ur = ua % ub;
    q = (a_neg ^ b_neg) ? -uq : uq;
    r = a_neg ? -ur : ur;
    div_res = b_zero ? {a, {WIDTH{1'b1}}} : {r, q};
    res = (op == OP_MULT || op == OP_MULTU) ? prod :
          (op == OP_MADD || op == OP_MADDU) ? hilo + prod :
          (op == OP_MSUB || op == OP_MSUBU) ? hilo - prod :
          is_div_class(op) ? div_res : '0;
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit with cancel; results commit only on completion
module mult_div_unit import mult_div_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic clk,
  input logic reset,
  mult_div_if.slave bus
);
  localparam int MAX_LAT = MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT) + 1;
  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d, arith_res;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               run, accept, launch, commit, stop;
  mult_div_arith #(.WIDTH(WIDTH)) u_arith (
    .op(bus.op), .a(bus.a), .b(bus.b), .hilo({hi_q, lo_q}), .res(arith_res)
  );
  assign run    = state_q == S_RUN;
  assign accept = bus.start && !run && !bus.cancel;
  assign launch = accept && (is_mult_class(bus.op) || is_div_class(bus.op));
  assign stop   = run && (bus.cancel || cnt_q == CW'(1));
  assign commit = stop && !bus.cancel;
  always_comb begin
    state_d = launch ? S_RUN : stop ? S_IDLE : state_q;
    cnt_d   = launch ? (is_div_class(bus.op) ? CW'(DIV_LAT) : CW'(MULT_LAT)) :
              stop ? '0 : run ? cnt_q - CW'(1) : cnt_q;
    res_d   = launch ? arith_res : res_q;
    hi_d    = commit ? res_q[2*WIDTH-1:WIDTH] : (accept && bus.op == OP_MTHI) ? bus.a : hi_q;
    lo_d    = commit ? res_q[WIDTH-1:0] : (accept && bus.op == OP_MTLO) ? bus.a : lo_q;
    done_d  = commit;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy = run;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench; expected {HI,LO} queued at issue, checked on each done pulse
module tb_mult_div_unit;
  import mult_div_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mult_div_if #(.WIDTH(32)) bus ();
  mult_div_if #(.WIDTH(8))  bus8 ();
  mult_div_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  mult_div_unit #(.WIDTH(8), .MULT_LAT(1), .DIV_LAT(3)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  int checks = 0;
  int failures = 0;
  int dones = 0;
  logic [63:0] exp_q[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        chk("result_hilo", {bus.hi, bus.lo}, exp_q.pop_front());
      end
    end
  end
  // called at a negedge; returns at the first negedge with busy low
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input string name);
    int n = 0;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'(lat));
  endtask
  initial begin
    int n;
    bus.start = 1'b0; bus.op = OP_NOP; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    bus8.start = 1'b0; bus8.op = OP_NOP; bus8.a = '0; bus8.b = '0; bus8.cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 5, "mult");
    run_op(OP_MTHI, 32'h0, 32'h0, 0, "mthi");
    chk("mthi_hi", 64'(bus.hi), 64'h0);
    run_op(OP_MTLO, 32'hFFFFFFFF, 32'h0, 0, "mtlo");
    chk("mtlo_lo", 64'(bus.lo), 64'hFFFFFFFF);
    chk("mt_no_done", 64'(bus.done), 64'h0);
    exp_q.push_back({32'h1, 32'h0});
    run_op(OP_MADDU, 32'd1, 32'd1, 5, "maddu");
    exp_q.push_back({32'h0, 32'hFFFFFFFF});
    run_op(OP_MSUB, 32'd1, 32'd1, 5, "msub");
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 10, "div_neg");
    exp_q.push_back({32'h5, 32'hFFFFFFFF});
    run_op(OP_DIV, 32'd5, 32'd0, 10, "div_zero");
    exp_q.push_back({32'h0, 32'h80000000});
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, "div_ovf");
    // cancel on cycle 4, with an ignored start while busy
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("cancel_busy_started", 64'(bus.busy), 64'h1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel4_busy", 64'(bus.busy), 64'h0);
    repeat (15) @(negedge clk);
    chk("cancel4_hilo", {bus.hi, bus.lo}, {32'h0, 32'h80000000});
    chk("cancel4_idle", 64'(bus.busy), 64'h0);
    // cancel exactly on the completion edge
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("cancel_end_still_busy", 64'(bus.busy), 64'h1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_end_busy", 64'(bus.busy), 64'h0);
    chk("cancel_end_done", 64'(bus.done), 64'h0);
    chk("cancel_end_hilo", {bus.hi, bus.lo}, {32'h0, 32'h80000000});
    // back-to-back: second start lands on the first idle cycle
    exp_q.push_back({32'h0, 32'd6});
    run_op(OP_MULTU, 32'd2, 32'd3, 5, "multu_b2b1");
    exp_q.push_back({32'h0, 32'd20});
    run_op(OP_MULTU, 32'd4, 32'd5, 5, "multu_b2b2");
    // asynchronous reset mid-op
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("async_reset", {bus.busy, bus.done, bus.hi, bus.lo}, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("reset_discard", {bus.busy, bus.hi, bus.lo}, '0);
    // 8-bit instance, MULT_LAT=1, DIV_LAT=3
    bus8.start = 1'b1; bus8.op = OP_MULTU; bus8.a = 8'hFF; bus8.b = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    chk("w8_multu_busy", 64'(bus8.busy), 64'h1);
    @(negedge clk);
    chk("w8_multu_idle", 64'(bus8.busy), 64'h0);
    chk("w8_multu_done", 64'(bus8.done), 64'h1);
    chk("w8_multu_hilo", 64'({bus8.hi, bus8.lo}), 64'hFE01);
    bus8.start = 1'b1; bus8.op = OP_DIV; bus8.a = 8'hF9; bus8.b = 8'h02;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 0;
    while (bus8.busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("w8_div_busy_cycles", 64'(n), 64'd3);
    chk("w8_div_hilo", 64'({bus8.hi, bus8.lo}), 64'hFFFD);
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(dones), 64'd8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multiply/divide unit for the EX stage, succeeding the fixed 32-bit HI/LO unit. It adds configurable operand width and per-class latencies, multiply-accumulate ops (MADD/MSUB family), defined divide-by-zero results, and a cancel input for exception flush. It exposes `busy` so pipeline control stalls later HI/LO users. Results commit to HI/LO only on completion, so a cancelled op leaves architectural state untouched.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width (≥ 2)
- `MULT_LAT`, 5, busy cycles for multiply-class ops (≥ 1)
- `DIV_LAT`, 10, busy cycles for divide-class ops (≥ 1)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  op request, sampled at a rising edge
- `op`  in  4  operation code (package encoding)
- `a`  in  WIDTH  rs operand
- `b`  in  WIDTH  rt operand
- `cancel`  in  1  abort the in-flight op (exception flush)
- `busy`  out  1  op in flight
- `done`  out  1  one-cycle pulse after a commit
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- Ops:
  - 0 NOP
  - 1 MULT, 2 MULTU
  - 3 DIV, 4 DIVU
  - 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU
  - 9 MTHI, 10 MTLO
  - 11–15 treated as NOP.
- Multiply: the 2·WIDTH product is written as {HI,LO}. Signed or unsigned per op.
- MADD/MSUB: {HI,LO} ± product, modulo 2^(2·WIDTH). The accumulate base is the HI/LO value at the accept edge.
- Divide: LO = quotient, HI = remainder, truncating toward zero. Remainder takes the sign of the dividend.
  - b = 0: LO = all ones, HI = a.
  - Signed MIN / −1: LO = MIN, HI = 0.
- MTHI/MTLO: write `a` at the accept edge. No busy, no done.
- Accept: `start` && !`busy` && !`cancel` at a rising edge.
  - `start` while busy is ignored; pipeline control must stall.
  - The full result is computed at accept into an internal result register.
  - A counter is loaded with the latency for the op class.
- States:
  - IDLE → RUN on accept of a mult/div-class op.
  - RUN → IDLE when the counter reaches 1: HI/LO ← result, `done` pulses.
  - RUN → IDLE on `cancel`: no commit, no `done`.
- `cancel` in IDLE has no effect. If `cancel` and `start` arrive together, start is dropped.
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
  - Reset mid-op discards the op.

## Timing
- Accept at edge E0.
  - `busy`=1 from E0 to E0+LAT, exactly LAT cycles.
  - HI/LO update at edge E0+LAT; `busy` falls at that same edge.
  - `done`=1 for the cycle after E0+LAT.
- Back-to-back: a new `start` is accepted at E0+LAT+1, the first cycle `busy`=0. Zero dead cycles.
- `cancel` sampled at E0+LAT (the completion edge) wins: no commit.
- MTHI/MTLO visible on `hi`/`lo` the cycle after the accept edge.
- `hi`/`lo` are registered outputs. The result register is not visible on the outputs before commit.

## Structure
- Shared package `mult_div_pkg`:
  - op code constants
  - `MD_OP_WIDTH` = 4
  - state encoding (IDLE/RUN)
  - op-class predicates (`is_mult_class`, `is_div_class`, `is_mt`)
- Sub-module `mult_div_arith`: combinational product/quotient/remainder for the given op, WIDTH-parametrised, including the special divide cases and the accumulate.
- Top holds the FSM, latency counter (width `$clog2(max(MULT_LAT,DIV_LAT))+1`), result register and HI/LO.

## Test plan
- MULT a=−3 (0xFFFFFFFD), b=7 → `busy` high for 5 cycles → HI=0xFFFFFFFF, LO=0xFFFFFFEB, one `done` pulse.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 → HI=1, LO=0. Then MSUB a=1, b=1 → HI=0, LO=0xFFFFFFFF.
- DIV a=−7, b=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV a=5, b=0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU in flight, `cancel` on cycle 4, and separately on the completion edge → HI/LO keep prior values, no `done`, `busy` low next cycle. `start` while busy is ignored.
- Back-to-back MULTU at the first idle cycle; `reset` low mid-op → all outputs 0 immediately. Re-run with WIDTH=8, MULT_LAT=1, DIV_LAT=3: MULTU 0xFF×0xFF → HI=0xFE, LO=0x01 after 1 cycle.
